add_round_key_stream: RTL and testbench

//  Registered, streaming AddRoundKey stage with an internal round-key bank.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/rk_bank.sv | 48 ++++
 rtl/add_round_key_stream.sv | 95 +++++++++
 tb/tb_add_round_key_stream.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and byte/state helpers. Byte 0 of a block sits in [127:120]
// and maps to row 0 / column 0; bytes fill the state column by column.
package aes_pkg;

  localparam int NB     = 4;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef logic [127:0] block_t;
  // Indexed as state[col][row], so the packed layout matches the block layout.
  typedef logic [0:NB-1][0:3][7:0] state_t;

  function automatic state_t blk2state(input block_t b);
    state_t s;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        s[c][r] = b[127 - 8 * (4 * c + r) -: 8];
      end
    end
    return s;
  endfunction

  function automatic block_t state2blk(input state_t s);
    block_t b;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        b[127 - 8 * (4 * c + r) -: 8] = s[c][r];
      end
    end
    return b;
  endfunction

  function automatic state_t add_key(input state_t s, input state_t k);
    state_t o;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[c][r] = s[c][r] ^ k[c][r];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/rk_bank.sv
// Round-key register file: one write port, one asynchronous read port and a
// per-entry valid bit that a synchronous clear wipes in one cycle.
module rk_bank
  import aes_pkg::*;
#(
  parameter int NUM_RK = 11,
  parameter int IDX_W  = $clog2(NUM_RK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  block_t           wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output block_t           rd_key,
  output logic             rd_hit
);

  block_t            mem [NUM_RK];
  logic [NUM_RK-1:0] vld;
  logic              wr_ok;
  logic              rd_in_range;

  // A clear in the same cycle drops the write entirely.
  assign wr_ok       = wr_en && !clr && (32'(wr_idx) < NUM_RK);
  assign rd_in_range = 32'(rd_idx) < NUM_RK;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (clr) begin
      vld <= '0;
    end else if (wr_ok) begin
      vld[wr_idx] <= 1'b1;
    end
  end

  assign rd_key = rd_in_range ? mem[rd_idx] : '0;
  assign rd_hit = rd_in_range && vld[rd_idx];

endmodule

// File: rtl/add_round_key_stream.sv
// Registered AddRoundKey stage: XORs LANES state blocks with one round key
// taken from an explicit index or the auto-incrementing round counter.
module add_round_key_stream
  import aes_pkg::*;
#(
  parameter  int LANES  = 1,
  parameter  int NUM_RK = 11,
  localparam int IDX_W  = $clog2(NUM_RK)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rk_wr_en,
  input  logic [IDX_W-1:0]     rk_wr_idx,
  input  logic [127:0]         rk_wr_data,
  input  logic                 rk_clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*128-1:0] in_data,
  input  logic                 in_auto,
  input  logic [IDX_W-1:0]     in_rk_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*128-1:0] out_data,
  output logic [IDX_W-1:0]     out_rk_idx,
  output logic                 out_err
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge.
  // The single output register refills in the same cycle it drains, and its
  // contents stay frozen while out_valid is high and out_ready is low.

  logic [IDX_W-1:0]     rnd_cnt;
  logic [IDX_W-1:0]     sel_idx;
  logic                 accept;
  block_t               rk_key;
  logic                 rk_hit;
  state_t               key_st;
  logic [LANES*128-1:0] xor_data;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign sel_idx  = in_auto ? rnd_cnt : in_rk_idx;

  // The bank is read before the edge, so a same-cycle write is not yet visible.
  rk_bank #(
    .NUM_RK (NUM_RK),
    .IDX_W  (IDX_W)
  ) u_rk_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (rk_clr),
    .wr_en   (rk_wr_en),
    .wr_idx  (rk_wr_idx),
    .wr_data (rk_wr_data),
    .rd_idx  (sel_idx),
    .rd_key  (rk_key),
    .rd_hit  (rk_hit)
  );

  assign key_st = blk2state(rk_key);

  always_comb begin
    xor_data = '0;
    for (int l = 0; l < LANES; l++) begin
      xor_data[l*128 +: 128] = state2blk(add_key(blk2state(in_data[l*128 +: 128]), key_st));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_cnt <= '0;
    end else if (rk_clr) begin
      rnd_cnt <= '0;
    end else if (accept && in_auto) begin
      rnd_cnt <= (rnd_cnt == IDX_W'(NUM_RK - 1)) ? '0 : rnd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_rk_idx <= '0;
      out_err    <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= rk_hit ? xor_data : in_data;
      out_rk_idx <= sel_idx;
      out_err    <= !rk_hit;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_round_key_stream.sv
// Bench for add_round_key_stream (LANES=2, NUM_RK=11): reference model with an
// expected-beat queue, directed AES vectors, back-pressure, auto index and reset cases.
module tb_add_round_key_stream;

  localparam int LANES  = 2;
  localparam int NUM_RK = 11;
  localparam int IDX_W  = 4;
  localparam int DW     = LANES * 128;
  localparam int QW     = 1 + IDX_W + DW;

  localparam logic [127:0] K0 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K1 = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] K2 = 128'h90973450696ccffaf2f457330b0fac99;
  localparam logic [127:0] E1 = 128'hf9fbfbaa9b9898c9f9fbfbaa9b9898c9;
  localparam logic [127:0] E2 = 128'h696ccffaf2f457330b0fac9990973450;

  logic             clk;
  logic             rst_n;
  logic             rk_wr_en;
  logic [IDX_W-1:0] rk_wr_idx;
  logic [127:0]     rk_wr_data;
  logic             rk_clr;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             in_auto;
  logic [IDX_W-1:0] in_rk_idx;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [IDX_W-1:0] out_rk_idx;
  logic             out_err;

  add_round_key_stream #(
    .LANES  (LANES),
    .NUM_RK (NUM_RK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rk_wr_en   (rk_wr_en),
    .rk_wr_idx  (rk_wr_idx),
    .rk_wr_data (rk_wr_data),
    .rk_clr     (rk_clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_auto    (in_auto),
    .in_rk_idx  (in_rk_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rk_idx (out_rk_idx),
    .out_err    (out_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model + scoreboard ----------------
  logic [QW-1:0]    exp_q[$];
  logic [127:0]     m_key [16];
  logic [15:0]      m_vld;
  logic [IDX_W-1:0] m_cnt;
  logic             m_ov;
  logic             m_acc;
  logic [IDX_W-1:0] m_idx;
  logic             m_err;
  logic [DW-1:0]    m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov  = 1'b0;
      m_cnt = '0;
      m_vld = '0;
      m_acc = 1'b0;
      exp_q.delete();
    end else begin
      m_acc = in_valid && (!m_ov || out_ready);
      if (m_acc) begin
        m_idx  = in_auto ? m_cnt : in_rk_idx;
        m_err  = (m_idx >= NUM_RK) || !m_vld[m_idx];
        m_data = m_err ? in_data : (in_data ^ {LANES{m_key[m_idx]}});
        exp_q.push_back({m_err, m_idx, m_data});
        if (in_auto) m_cnt = (m_cnt == NUM_RK - 1) ? '0 : m_cnt + 1'b1;
      end
      if (m_acc) m_ov = 1'b1;
      else if (out_ready) m_ov = 1'b0;
      if (rk_clr) begin
        m_vld = '0;
        m_cnt = '0;
      end else if (rk_wr_en && rk_wr_idx < NUM_RK) begin
        m_key[rk_wr_idx] = rk_wr_data;
        m_vld[rk_wr_idx] = 1'b1;
      end
    end
  end

  logic [QW-1:0] mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (out_valid !== m_ov) begin
        bad++;
        $display("FAIL out_valid: got %b want %b", out_valid, m_ov);
      end
      total++;
      if (in_ready !== (!m_ov || out_ready)) begin
        bad++;
        $display("FAIL in_ready: got %b want %b", in_ready, !m_ov || out_ready);
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra_beat: got idx %0d with no expected beat", out_rk_idx);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_data !== mon_e[DW-1:0] || out_rk_idx !== mon_e[DW +: IDX_W] ||
              out_err !== mon_e[QW-1]) begin
            bad++;
            $display("FAIL sb_beat: got err=%b idx=%0d data=%h want err=%b idx=%0d data=%h",
                     out_err, out_rk_idx, out_data, mon_e[QW-1], mon_e[DW +: IDX_W], mon_e[DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    rk_wr_en = 0; rk_wr_idx = '0; rk_wr_data = '0; rk_clr = 0;
    in_valid = 0; in_data = '0; in_auto = 0; in_rk_idx = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [IDX_W-1:0] idx, input logic [127:0] key);
    rk_wr_en = 1; rk_wr_idx = idx; rk_wr_data = key;
    step();
    rk_wr_en = 0;
  endtask

  task automatic clear_bank();
    rk_clr = 1;
    step();
    rk_clr = 0;
  endtask

  task automatic send(input logic auto, input logic [IDX_W-1:0] idx, input logic [DW-1:0] d);
    int n;
    in_valid = 1; in_auto = auto; in_rk_idx = idx; in_data = d;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_acc && n < 50);
    if (!m_acc) begin
      total++; bad++;
      $display("FAIL send_timeout: got no accept in %0d cycles, want accept", n);
    end
    in_valid = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    out_ready = 1;
    rst_n = 0;
    step();
    step();
    total++;
    if (out_valid !== 0 || out_data !== '0 || out_rk_idx !== '0 || out_err !== 0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h i=%0d e=%b want all zero",
               out_valid, out_data, out_rk_idx, out_err);
    end
    total++;
    if (in_ready !== 1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    #2 rst_n = 1;
    step();
  endtask

  task automatic test_vectors();
    write_key(0, K0);
    write_key(1, K1);
    write_key(2, K2);
    send(0, 0, '0);
    total++;
    if (out_valid !== 1 || out_data !== {2{K0}} || out_err !== 0) begin
      bad++;
      $display("FAIL vec1: got v=%b e=%b d=%h want v=1 e=0 d=%h", out_valid, out_err, out_data, {2{K0}});
    end
    send(0, 1, {2{K0}});
    total++;
    if (out_data !== {2{E1}} || out_rk_idx !== 1 || out_err !== 0) begin
      bad++;
      $display("FAIL vec2: got i=%0d e=%b d=%h want i=1 e=0 d=%h", out_rk_idx, out_err, out_data, {2{E1}});
    end
    send(0, 2, {2{E1}});
    total++;
    if (out_data !== {2{E2}} || out_rk_idx !== 2 || out_err !== 0) begin
      bad++;
      $display("FAIL vec3: got i=%0d e=%b d=%h want i=2 e=0 d=%h", out_rk_idx, out_err, out_data, {2{E2}});
    end
    step();
  endtask

  task automatic test_auto();
    logic [DW-1:0] d;
    clear_bank();
    for (int i = 0; i < NUM_RK - 1; i++) begin
      write_key(IDX_W'(i), {$urandom, $urandom, $urandom, $urandom});
    end
    for (int i = 0; i <= NUM_RK; i++) begin
      d = {8{$urandom}};
      send(1, '0, d);
      total++;
      if (out_rk_idx !== IDX_W'(i % NUM_RK) || out_err !== (i == NUM_RK - 1)) begin
        bad++;
        $display("FAIL auto_idx: got i=%0d e=%b want i=%0d e=%b", out_rk_idx, out_err,
                 i % NUM_RK, i == NUM_RK - 1);
      end
      if (i == NUM_RK - 1) begin
        total++;
        if (out_data !== d) begin
          bad++;
          $display("FAIL auto_passthru: got %h want %h", out_data, d);
        end
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    send(1, '0, {8{$urandom}});
    in_valid = 1; in_auto = 1; in_data = {8{$urandom}};
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (in_ready !== 0 || exp_q.size() != 1) begin
        bad++;
        $display("FAIL stall_ready: got ready=%b queued=%0d want ready=0 queued=1", in_ready, exp_q.size());
      end else begin
        total++;
        if (out_data !== exp_q[0][DW-1:0]) begin
          bad++;
          $display("FAIL stall_hold: got %h want %h", out_data, exp_q[0][DW-1:0]);
        end
      end
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      send(1, '0, {8{$urandom}});
    end
    step();
  endtask

  task automatic test_same_cycle();
    logic [127:0] ka;
    logic [127:0] kb;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    write_key(3, ka);
    rk_wr_en = 1; rk_wr_idx = 3; rk_wr_data = kb;
    send(0, 3, '0);
    rk_wr_en = 0;
    total++;
    if (out_data !== {2{ka}} || out_err !== 0) begin
      bad++;
      $display("FAIL wr_rd_old: got e=%b d=%h want e=0 d=%h", out_err, out_data, {2{ka}});
    end
    send(0, 3, '0);
    total++;
    if (out_data !== {2{kb}}) begin
      bad++;
      $display("FAIL wr_rd_new: got %h want %h", out_data, {2{kb}});
    end
    rk_clr = 1; rk_wr_en = 1; rk_wr_idx = 5; rk_wr_data = ka;
    step();
    idle();
    send(0, 5, {2{K1}});
    total++;
    if (out_err !== 1 || out_data !== {2{K1}}) begin
      bad++;
      $display("FAIL clr_beats_wr: got e=%b d=%h want e=1 d=%h", out_err, out_data, {2{K1}});
    end
    send(0, 3, {2{K2}});
    total++;
    if (out_err !== 1) begin
      bad++;
      $display("FAIL clr_valid: got e=%b want 1", out_err);
    end
    write_key(12, ka);
    send(0, 12, {2{K0}});
    total++;
    if (out_err !== 1 || out_rk_idx !== 12 || out_data !== {2{K0}}) begin
      bad++;
      $display("FAIL out_of_range: got e=%b i=%0d d=%h want e=1 i=12 d=%h",
               out_err, out_rk_idx, out_data, {2{K0}});
    end
    step();
  endtask

  task automatic test_random();
    bit stop;
    stop = 0;
    for (int i = 0; i < 8; i++) write_key(IDX_W'(i), {$urandom, $urandom, $urandom, $urandom});
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send(1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 15)), {8{$urandom}});
        end
        stop = 1;
      end
      begin
        while (!stop) begin
          out_ready = 1'($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    out_ready = 1;
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    send(0, 0, {8{$urandom}});
    #2 rst_n = 0;
    #1;
    total++;
    if (out_valid !== 0 || out_data !== '0) begin
      bad++;
      $display("FAIL async_reset: got v=%b d=%h want v=0 d=0", out_valid, out_data);
    end
    out_ready = 1;
    step();
    #2 rst_n = 1;
    write_key(4, K1);
    send(0, 4, {2{K0}});
    total++;
    if (out_data !== {2{E1}} || out_err !== 0) begin
      bad++;
      $display("FAIL after_reset: got e=%b d=%h want e=0 d=%h", out_err, out_data, {2{E1}});
    end
    step();
  endtask

  initial begin
    int n;
    test_reset();
    test_vectors();
    test_auto();
    test_back_to_back();
    test_same_cycle();
    test_random();
    test_reset_mid();
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d beats outstanding want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
